cnn_layer_accel_awe_row_stride_buffer: RTL
==========================================

CNN_LAYER_ACCEL_AWE_ROW_STRIDE_BUFFER -- requirements
Module: cnn_layer_accel_awe_row_stride_buffer

Interface
REQ-001: Parameter C_DATA_WIDTH, default 16, sample width; matches the upstream column stride stage.
REQ-002: Parameter C_FIFO_DEPTH, default 16, output FIFO entries; power of two, 4 or more.
REQ-003: Parameter C_COL_WIDTH, default 10, width of the row-width and row-count configuration fields.
REQ-004: Port clk, input, 1 bit; the only clock.
REQ-005: Port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-006: Port config_valid, input, 1 bit; single-cycle pulse that latches the configuration and starts a frame.
REQ-007: Port stride_size, input, clog2(`MAX_STRIDE) bits; row stride minus one (0 means keep every row).
REQ-008: Port row_width, input, C_COL_WIDTH bits; column-decimated samples per row, minus one.
REQ-009: Port num_rows, input, C_COL_WIDTH bits; input rows per frame, minus one.
REQ-010: Port datain, input, C_DATA_WIDTH bits; column-decimated sample.
REQ-011: Port datain_valid, input, 1 bit; sample qualifier; there is no upstream backpressure.
REQ-012: Port dataout, output, C_DATA_WIDTH bits; FIFO head.
REQ-013: Port dataout_valid, output, 1 bit; FIFO not empty.
REQ-014: Port dataout_ready, input, 1 bit; downstream accept.
REQ-015: Port dataout_row_last, output, 1 bit; the head sample is the last of a kept row.
REQ-016: Port dataout_frame_last, output, 1 bit; the head sample is the last of the frame.
REQ-017: Port almost_full, output, 1 bit; high when the FIFO holds C_FIFO_DEPTH-2 or more entries.
REQ-018: Port overflow, output, 1 bit; sticky; a kept sample arrived while the FIFO was full.
REQ-019: Port frame_done, output, 1 bit; one-cycle pulse after the last frame sample is popped.

Function
REQ-020: The controller state machine SHALL have three states: IDLE, RUN and DRAIN.
- IDLE to RUN on config_valid.
- RUN to DRAIN when the sample at column row_width of row num_rows is accepted.
- DRAIN to IDLE when the FIFO is empty; frame_done pulses in that transition cycle.
REQ-021: In IDLE, datain_valid SHALL be ignored, and config_valid SHALL be ignored in RUN and DRAIN.
REQ-022: In RUN, col_cnt SHALL count valid samples from 0 to row_width, then wrap to 0 and advance row_cnt.
REQ-023: phase_cnt SHALL start at 0, advance with each row, and wrap after stride_size.
- A row is kept when phase_cnt is 0, so row 0 is always kept.
- This uses the same minus-one stride encoding as the column stride stage.
REQ-024: Every valid sample in a kept row SHALL be pushed with row_last set when col_cnt equals row_width.
- frame_last is also set on the last sample of the last kept row.
- Samples in dropped rows SHALL be discarded, but they still advance col_cnt and row_cnt.
REQ-025: The "last kept row" SHALL be computed at config time as the largest row index at or below num_rows whose index mod (stride_size+1) is 0.
REQ-026: Push to output visibility latency SHALL be 1 cycle (registered FIFO write; dataout is driven combinationally from the FIFO RAM head).
REQ-027: A pop occurs when dataout_valid and dataout_ready are both high.
- A simultaneous push and pop SHALL leave the occupancy unchanged.
- When the FIFO is full, a simultaneous push and pop SHALL succeed.
REQ-028: A push while the FIFO is full with no pop SHALL drop the sample and set overflow.
- overflow is cleared only by reset or the next config_valid.
REQ-029: Read and write pointers SHALL be clog2(C_FIFO_DEPTH)+1 bits wide.
- Full and empty are decided from the pointers' MSB difference.

Reset
REQ-030: While rst is low, the following SHALL hold:
- state = IDLE.
- All counters and pointers = 0.
- dataout_valid, dataout_row_last, dataout_frame_last, almost_full, overflow and frame_done = 0.
- dataout = 0.
REQ-031: Reset assertion mid-frame SHALL discard FIFO contents immediately.
- After deassertion, the next frame requires a new config_valid.

Structure
REQ-032: `MAX_STRIDE and the state enumeration SHALL reside in the shared cnn_layer_accel_defs.vh.
- Width helpers SHALL come from math.vh.
REQ-033: The FIFO SHALL be a sub-module, cnn_layer_accel_sync_fifo.
- Its width is C_DATA_WIDTH+2, carrying the two tag bits.
- The sub-module exposes full, empty and almost_full.

Verification
REQ-034: stride_size=1, row_width=3, num_rows=3, 16 samples with values 0..15, ready held high.
- Required response: outputs 0..3 and 8..11.
- row_last on 3 and 11; frame_last on 11.
- frame_done 1 cycle after 11 is popped.
REQ-035: stride_size=0, row_width=1, num_rows=1, values 0..3.
- Required response: all four are output.
- row_last on 1 and 3; frame_last on 3.
REQ-036: Depth 16, ready held low, 17 kept samples.
- almost_full is high after 14 samples.
- overflow goes high on the 17th, which is absent from the output.
- After ready rises, 16 samples drain in order.
REQ-037: FIFO full, then push and pop in the same cycle.
- Required response: occupancy stays 16 and overflow stays 0.
REQ-038: rst pulsed low mid-RUN with 5 entries buffered.
- dataout_valid drops to 0 asynchronously.
- Post-reset samples are ignored until config_valid.
REQ-039: config_valid during DRAIN.
- Required response: it is ignored and frame_done still pulses once.

Source files
------------

// File: rtl/cnn_layer_accel_awe_row_stride_buffer_pkg.sv
// Shared types and helpers for the row stride buffer: stride limit,
// controller state encoding and the last-kept-row calculation.
package cnn_layer_accel_awe_row_stride_buffer_pkg;

  localparam int MAX_STRIDE = 8;
  localparam int STRIDE_W   = $clog2(MAX_STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rsb_state_e;

  // Largest row index <= rows that lands on a stride phase of zero.
  function automatic int unsigned last_kept_row(input int unsigned rows,
                                                input int unsigned stride_m1);
    return rows - (rows % (stride_m1 + 1));
  endfunction

endpackage

// File: rtl/cnn_layer_accel_sync_fifo.sv
// Single-clock FIFO with extended pointers; head is read combinationally
// and forced to zero while empty so nothing stale leaks downstream.
module cnn_layer_accel_sync_fifo
  import cnn_layer_accel_awe_row_stride_buffer_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_wr;
  logic         do_rd;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= (AW+1)'(DEPTH - 2));

  // A write into a full FIFO is allowed when the same cycle frees a slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cnn_layer_accel_awe_row_stride_buffer.sv
// Row decimation stage: keeps every (stride_size+1)-th row of a frame,
// tags row/frame ends and buffers kept samples in an output FIFO.
module cnn_layer_accel_awe_row_stride_buffer
  import cnn_layer_accel_awe_row_stride_buffer_pkg::*;
#(
  parameter int C_DATA_WIDTH = 16,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_COL_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    config_valid,
  input  logic [STRIDE_W-1:0]     stride_size,
  input  logic [C_COL_WIDTH-1:0]  row_width,
  input  logic [C_COL_WIDTH-1:0]  num_rows,
  input  logic [C_DATA_WIDTH-1:0] datain,
  input  logic                    datain_valid,
  output logic [C_DATA_WIDTH-1:0] dataout,
  output logic                    dataout_valid,
  input  logic                    dataout_ready,
  output logic                    dataout_row_last,
  output logic                    dataout_frame_last,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    frame_done
);

  localparam int FW = C_DATA_WIDTH + 2;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] ONE_LEFT = {{AW{1'b0}}, 1'b1};

  rsb_state_e             state;
  logic [STRIDE_W-1:0]    stride_r;
  logic [C_COL_WIDTH-1:0] row_width_r;
  logic [C_COL_WIDTH-1:0] num_rows_r;
  logic [C_COL_WIDTH-1:0] last_kept_r;
  logic [C_COL_WIDTH-1:0] col_cnt;
  logic [C_COL_WIDTH-1:0] row_cnt;
  logic [STRIDE_W-1:0]    phase_cnt;

  logic          accept;
  logic          col_last;
  logic          row_kept;
  logic          frame_end;
  logic          push;
  logic          pop;
  logic [FW-1:0] wr_data;
  logic [FW-1:0] rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;

  assign accept    = (state == ST_RUN) && datain_valid;
  assign col_last  = (col_cnt == row_width_r);
  assign row_kept  = (phase_cnt == '0);
  assign frame_end = accept && col_last && (row_cnt == num_rows_r);
  assign push      = accept && row_kept;
  assign pop       = dataout_valid && dataout_ready;
  assign wr_data   = {col_last && (row_cnt == last_kept_r), col_last, datain};

  cnn_layer_accel_sync_fifo #(
    .W     (FW),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (push),
    .wr_data     (wr_data),
    .rd_en       (dataout_ready),
    .rd_data     (rd_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (almost_full),
    .count       (fifo_count)
  );

  assign {dataout_frame_last, dataout_row_last, dataout} = rd_data;
  assign dataout_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      stride_r    <= '0;
      row_width_r <= '0;
      num_rows_r  <= '0;
      last_kept_r <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      phase_cnt   <= '0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (config_valid) begin
            stride_r    <= stride_size;
            row_width_r <= row_width;
            num_rows_r  <= num_rows;
            last_kept_r <= C_COL_WIDTH'(last_kept_row(32'(num_rows), 32'(stride_size)));
            col_cnt     <= '0;
            row_cnt     <= '0;
            phase_cnt   <= '0;
            overflow    <= 1'b0;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (col_last) begin
              col_cnt   <= '0;
              row_cnt   <= row_cnt + 1'b1;
              phase_cnt <= (phase_cnt == stride_r) ? '0 : phase_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            if (frame_end) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave as the last entry goes so frame_done lines up with the final pop.
          if (fifo_empty || (pop && fifo_count == ONE_LEFT)) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
